// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// PS/2 keyboard receiver and scan-code decoder. It feeds the key-state
// interface that the game logic reads.
//
// The raw ps2_clk and ps2_data lines are synchronised. ps2_clk is then
// glitch-filtered. Each falling edge of the filtered clock advances an
// 11-bit frame receiver (start, 8 data bits LSB first, odd parity, stop).
// Good bytes are decoded against the E0 (extended) and F0 (break) prefixes
// into a 512-entry key bitmap indexed by {ext, code}.
//
// Parameters:
//   FILTER_LEN      consecutive equal samples before the filtered clock moves
//   TIMEOUT_CYCLES  clk cycles without a fall strobe mid-frame before abort
//
// Configuration macro:
//   KEY_TYPEMATIC_FILTER_EN  when defined, a make code for a key that is
//                            already held (auto-repeat) produces no event.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active low (0 = reset)
//   ps2_clk      in   raw PS/2 clock, asynchronous
//   ps2_data     in   raw PS/2 data, asynchronous
//   key_down     out  bit {ext,code} is 1 while that key is held
//   last_change  out  {ext,code} of the most recent make/break event
//   been_ready   out  1-cycle pulse: key_down/last_change were just updated
//   frame_err    out  1-cycle pulse: frame dropped (start/parity/stop/timeout)
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         been_ready,
  output logic         frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronisers. They reset to 1 because an idle PS/2 bus is high.
  // -------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      // NOTE: state registers use non-blocking assignments. Each stage then
      // reads the value its neighbour held before the edge, which is what
      // makes this a two-stage shift rather than a single wire.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // -------------------------------------------------------------------------
  // Clock filter. flt_cnt counts consecutive samples that disagree with the
  // current filtered level. Any agreeing sample restarts the count, so a
  // glitch shorter than FILTER_LEN never moves the filtered clock.
  // -------------------------------------------------------------------------
  logic [FW-1:0] flt_cnt;
  logic          flt_clk;
  logic          flt_clk_d;
  logic          fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flt_cnt   <= '0;
      flt_clk   <= 1'b1;
      flt_clk_d <= 1'b1;
    end else begin
      flt_clk_d <= flt_clk;
      if (clk_s == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_clk <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign fall = flt_clk_d & ~flt_clk;

  // -------------------------------------------------------------------------
  // Frame receiver FSM
  // -------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          par_bit, par_nxt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          start_err;
  logic          stop_good;
  logic          stop_bad;
  logic          timeout;

  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par_bit;
    start_err   = 1'b0;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    timeout     = 1'b0;

    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
          end else begin
            start_err = 1'b1;
          end
        end
        ST_DATA: begin
          shift_nxt   = {data_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          par_nxt   = data_s;
          state_nxt = ST_STOP;
        end
        ST_STOP: begin
          state_nxt = ST_IDLE;
          if (data_s && (^{shift, par_bit})) stop_good = 1'b1;
          else                               stop_bad  = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_hit) begin
      state_nxt = ST_IDLE;
      timeout   = 1'b1;
    end
  end

  // The timeout counter only runs while a frame is in flight. It saturates
  // at the terminal count; the FSM leaves mid-frame on that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (fall || state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Scan-code decoder. The received byte is decoded on the STOP fall strobe.
  // The results appear on the outputs one clk later.
  // -------------------------------------------------------------------------
  logic       ext, ext_nxt;
  logic       brk, brk_nxt;
  logic       err_nxt;
  logic       ev_nxt;
  logic [8:0] key;

  assign key     = {ext, shift};
  assign err_nxt = start_err | stop_bad | timeout;

  always_comb begin
    ext_nxt = ext;
    brk_nxt = brk;
    ev_nxt  = 1'b0;
    if (err_nxt) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (stop_good) begin
      if (shift == CODE_EXT) begin
        ext_nxt = 1'b1;
      end else if (shift == CODE_BRK) begin
        brk_nxt = 1'b1;
      end else begin
        ext_nxt = 1'b0;
        brk_nxt = 1'b0;
`ifdef KEY_TYPEMATIC_FILTER_EN
        // An auto-repeated make for a key that is already held is swallowed.
        ev_nxt  = brk | ~key_down[key];
`else
        ev_nxt  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      been_ready  <= 1'b0;
      frame_err   <= 1'b0;
      last_change <= '0;
      // NOTE: the key bitmap is a wide state array that is cleared on reset.
      // After a reset the game logic must see no keys held, even if a break
      // code was lost mid-frame.
      key_down    <= '0;
    end else begin
      ext        <= ext_nxt;
      brk        <= brk_nxt;
      been_ready <= ev_nxt;
      frame_err  <= err_nxt;
      if (ev_nxt) begin
        key_down[key] <= ~brk;
        last_change   <= key;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Self-checking bench for ps2_key_decoder. It drives PS/2 frames bit by bit.
// A reference model of the prefix and key-state rules pushes the expected
// event (key code plus the full bitmap after the event) into a queue when a
// frame is sent. A monitor pops and compares an entry on every been_ready.
// Frame errors are counted against the number the model expects.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 20;   // clk cycles per PS/2 half period

  logic         clk = 1'b0;
  logic         rst;
  logic         ps2_clk;
  logic         ps2_data;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         been_ready;
  logic         frame_err;

  ps2_key_decoder #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_down   (key_down),
    .last_change(last_change),
    .been_ready (been_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]   key;
    logic [511:0] kd;
  } ev_t;

  ev_t          exp_q[$];
  logic [511:0] m_kd;
  logic         m_ext;
  logic         m_brk;
  int           exp_err;
  int           n_err_seen;
  int           n_ready;
  int           n_tests;
  int           n_fail;
  logic         br_prev;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decode one byte the way the keyboard protocol defines.
  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [8:0] k;
    if (!good) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      k = {m_ext, b};
`ifdef KEY_TYPEMATIC_FILTER_EN
      if (m_brk || !m_kd[k]) begin
        m_kd[k] = ~m_brk;
        exp_q.push_back('{key: k, kd: m_kd});
      end
`else
      m_kd[k] = ~m_brk;
      exp_q.push_back('{key: k, kd: m_kd});
`endif
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends a full frame. flip_par corrupts parity. glitch_at >= 0 inserts a
  // 3-clk low pulse on ps2_clk after that bit.
  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input int glitch_at);
    logic [10:0] bits;
    bits = {1'b1, ~(^b) ^ flip_par, b, 1'b0};
    model_byte(b, !flip_par);
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i]);
      if (i == glitch_at) begin
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check({tag, "_queue_empty"}, 512'(exp_q.size()), 512'd0);
    check({tag, "_err_cnt"}, 512'(n_err_seen), 512'(exp_err));
  endtask

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) n_err_seen++;
      if (been_ready && frame_err) check("ready_err_overlap", 1, 0);
      if (been_ready && br_prev) check("ready_width", 1, 0);
      if (been_ready) begin
        n_ready++;
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("last_change", 512'(last_change), 512'(e.key));
          check("key_down", key_down, e.kd);
        end
      end
    end
    br_prev = been_ready;
  end

  initial begin
    int r0;
    n_tests = 0; n_fail = 0; exp_err = 0; n_err_seen = 0; n_ready = 0;
    m_kd = '0; m_ext = 1'b0; m_brk = 1'b0; br_prev = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1; rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_key_down", key_down, '0);
    check("rst_last_change", 512'(last_change), 512'd0);
    check("rst_flags", 512'({been_ready, frame_err}), 512'd0);
    rst = 1'b1;
    repeat (10) @(posedge clk);

    // Plain make code.
    send_frame(8'h1C, 0, -1);
    drain("make_1c");
    #1 check("kd_01c", 512'(key_down[9'h01C]), 512'd1);

    // Extended make then extended break.
    r0 = n_ready;
    send_frame(8'hE0, 0, -1);
    send_frame(8'h72, 0, -1);
    send_frame(8'hE0, 0, -1);
    send_frame(8'hF0, 0, -1);
    send_frame(8'h72, 0, -1);
    drain("ext_72");
    check("ext_pulses", 512'(n_ready - r0), 512'd2);
    #1 check("kd_172", 512'(key_down[9'h172]), 512'd0);

    // Bad parity, then the same code correctly.
    send_frame(8'h6B, 1, -1);
    drain("bad_par");
    #1 check("kd_06b_after_bad", 512'(key_down[9'h06B]), 512'd0);
    send_frame(8'h6B, 0, -1);
    drain("good_6b");

    // Prefix cleared by an error: E0, corrupted frame, then 72 is not extended.
    send_frame(8'hE0, 0, -1);
    send_frame(8'h11, 1, -1);
    send_frame(8'h72, 0, -1);
    drain("prefix_clear");

    // Timeout: start + 4 data bits, then the bus goes quiet.
    model_byte(8'h00, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 100) @(posedge clk);
    drain("timeout");
    send_frame(8'h74, 0, -1);
    drain("after_timeout");

    // Clock glitch inside a frame must not shift in an extra bit.
    send_frame(8'h29, 0, 4);
    drain("glitch");

    // Auto-repeat make.
    r0 = n_ready;
    send_frame(8'h75, 0, -1);
    send_frame(8'h75, 0, -1);
    drain("typematic");
`ifdef KEY_TYPEMATIC_FILTER_EN
    check("typematic_pulses", 512'(n_ready - r0), 512'd1);
`else
    check("typematic_pulses", 512'(n_ready - r0), 512'd2);
`endif
    #1 check("kd_075", 512'(key_down[9'h075]), 512'd1);

    // Reset in the middle of a frame.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_key_down", key_down, '0);
    check("midrst_outs", 512'({last_change, been_ready, frame_err}), 512'd0);
    m_kd = '0; m_ext = 1'b0; m_brk = 1'b0;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    send_frame(8'hAA, 0, -1);
    drain("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
